// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard controller bundle: pipeline observations in, latch enables/flushes out.
// master = pipeline side that supplies IF/ID and ID/EX fields; slave = the controller.
interface id_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr_IF_ID;
  logic             idex_MemRead;
  logic [4:0]       idex_rt;
  logic             branch_taken;
  logic             mem_stall;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             ctrl_zero;
  logic             if_flush;
  logic             ex_flush;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_count;
  logic             state;

  modport master (
    output instr_IF_ID, idex_MemRead, idex_rt, branch_taken, mem_stall,
    input  PCWrite, IFIDWrite, ctrl_zero, if_flush, ex_flush, pipe_hold, stall_count, state
  );

  modport slave (
    input  instr_IF_ID, idex_MemRead, idex_rt, branch_taken, mem_stall,
    output PCWrite, IFIDWrite, ctrl_zero, if_flush, ex_flush, pipe_hold, stall_count, state
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage load-use stall / branch flush / memory freeze sequencer; Mealy outputs, 0-cycle latency.
// mem_stall freezes all state and holds the pipe; taken branches abort any stall window.
module id_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            rst,
  id_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e           state_q, state_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  logic [5:0] opcode;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       hazard;
  logic       bubble;
  logic       unused_instr_bits;

  assign opcode            = bus.instr_IF_ID[31:26];
  assign rs                = bus.instr_IF_ID[25:21];
  assign rt                = bus.instr_IF_ID[20:16];
  assign unused_instr_bits = ^bus.instr_IF_ID[15:0];

  // Only R-type, beq and sw actually read rt as a source operand.
  assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);

  assign hazard = bus.idex_MemRead && (bus.idex_rt != 5'd0) &&
                  ((bus.idex_rt == rs) || (uses_rt && (bus.idex_rt == rt)));

  // In STALL the load has already moved past ID/EX, so the hazard term is irrelevant there.
  assign bubble = (state_q == STALL) || hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      bcnt_q        <= 2'd0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      bcnt_q        <= bcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bcnt_d        = bcnt_q;
    stall_count_d = stall_count_q;
    if (bus.mem_stall) begin
      state_d       = state_q;
      bcnt_d        = bcnt_q;
      stall_count_d = stall_count_q;
    end else if (bus.branch_taken) begin
      state_d = RUN;
      bcnt_d  = 2'd0;
    end else if (bubble) begin
      if (stall_count_q != {CNT_W{1'b1}}) begin
        stall_count_d = stall_count_q + 1'b1;
      end
      if (state_q == RUN) begin
        if (LOAD_BUBBLES > 1) begin
          state_d = STALL;
          bcnt_d  = BCNT_INIT;
        end
      end else if (bcnt_q == 2'd1) begin
        state_d = RUN;
        bcnt_d  = 2'd0;
      end else begin
        bcnt_d = bcnt_q - 2'd1;
      end
    end
  end

  always_comb begin
    bus.PCWrite   = 1'b1;
    bus.IFIDWrite = 1'b1;
    bus.ctrl_zero = 1'b0;
    bus.if_flush  = 1'b0;
    bus.ex_flush  = 1'b0;
    bus.pipe_hold = 1'b0;
    if (rst) begin
      bus.PCWrite   = 1'b0;
      bus.IFIDWrite = 1'b0;
      bus.ctrl_zero = 1'b1;
    end else if (bus.mem_stall) begin
      bus.PCWrite   = 1'b0;
      bus.IFIDWrite = 1'b0;
      bus.pipe_hold = 1'b1;
    end else if (bus.branch_taken) begin
      bus.if_flush  = 1'b1;
      bus.ex_flush  = 1'b1;
      bus.ctrl_zero = 1'b1;
    end else if (bubble) begin
      bus.PCWrite   = 1'b0;
      bus.IFIDWrite = 1'b0;
      bus.ctrl_zero = 1'b1;
    end
  end

  assign bus.stall_count = stall_count_q;
  assign bus.state       = state_q;

endmodule

// File: doc/id_hazard_ctrl.md
# id_hazard_ctrl

Pipeline sequencing controller for the instruction-decode stage of the 5-stage MIPS pipeline. Detects load-use hazards between the instruction in IF/ID and a load in ID/EX, then stalls PC and IF/ID and injects bubbles into the ID/EX latch for a configurable number of cycles. Handles taken-branch flushes from MEM and whole-pipeline freezes from data memory. Keeps a saturating count of load-use bubble cycles.

## Interface
Parameters:
- LOAD_BUBBLES, 1, bubble cycles per load-use hazard; legal 1..3 (1 = full forwarding, 2/3 = partial/no MEM forwarding)
- CNT_W, 16, width of stall_count

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_IF_ID  in  32  instruction in ID; opcode [31:26], rs [25:21], rt [20:16]
- idex_MemRead  in  1  memory-read control bit of the instruction in ID/EX
- idex_rt  in  5  destination (rt) field held in ID/EX
- branch_taken  in  1  taken branch resolved in MEM this cycle
- mem_stall  in  1  data memory busy; freeze the whole pipeline
- PCWrite  out  1  PC load enable
- IFIDWrite  out  1  IF/ID latch load enable
- ctrl_zero  out  1  force the WB/M/EX control fields written into ID/EX to zero (bubble)
- if_flush  out  1  clear IF/ID on the next edge
- ex_flush  out  1  zero the control fields written into EX/MEM on the next edge
- pipe_hold  out  1  hold ID/EX and later latches
- stall_count  out  CNT_W  saturating count of load-use bubble cycles
- state  out  1  0 = RUN, 1 = STALL

## Operation
- Uses-rt decode: opcode 000000 (R-type), 000100 (beq), or 101011 (sw). All other opcodes compare rs only.
- hazard = idex_MemRead and idex_rt != 0 and (idex_rt == rs, or (uses-rt and idex_rt == rt)).
- FSM, 2 states, registered. bcnt is a 2-bit remaining-bubble counter.
- RUN: if hazard, not branch_taken, and not mem_stall: issue a bubble this cycle. If LOAD_BUBBLES > 1, go to STALL with bcnt = LOAD_BUBBLES-1. Otherwise stay in RUN.
- STALL: issue a bubble and decrement bcnt. When bcnt reaches 1 and is consumed, return to RUN. The hazard input is ignored in STALL, because the load has already left ID/EX.
- Bubble cycle: PCWrite = 0, IFIDWrite = 0, ctrl_zero = 1, stall_count += 1 (saturates at all-ones).
- Outputs are Mealy functions of state and current inputs. Priority, highest first:
  1. rst: PCWrite = 0, IFIDWrite = 0, ctrl_zero = 1, if_flush = 0, ex_flush = 0, pipe_hold = 0. On the next edge: state = RUN, bcnt = 0, stall_count = 0.
  2. mem_stall: PCWrite = 0, IFIDWrite = 0, pipe_hold = 1, ctrl_zero = 0, flushes = 0. State, bcnt and stall_count are frozen. branch_taken and hazard are ignored this cycle.
  3. branch_taken: PCWrite = 1, IFIDWrite = 1, if_flush = 1, ctrl_zero = 1, ex_flush = 1. Any stall is aborted: next state RUN, bcnt = 0. No count increment.
  4. Bubble: as defined above.
  5. Otherwise: PCWrite = 1, IFIDWrite = 1, all other outputs 0.

## Timing
- Hazard is visible in cycle t, with the lw in EX and the consumer in ID.
  - The bubble is asserted combinationally in cycle t.
  - For LOAD_BUBBLES = N, the bubble is asserted in cycles t..t+N-1.
  - PCWrite and IFIDWrite return to 1 in cycle t+N.
- A cycle with mem_stall inside a stall window extends the window by one cycle. bcnt is not decremented in that cycle.
- branch_taken in cycle t+k of a stall ends the stall: cycle t+k+1 is in RUN.
- state and stall_count change only on rising clk edges.
- No combinational path from any output back to any input.

## Test plan
- Reset: hold rst for 2 cycles with random inputs -> PCWrite = 0, ctrl_zero = 1, and after release state = 0, stall_count = 0.
- Load-use, LOAD_BUBBLES = 1: idex_MemRead = 1, idex_rt = 5, instr_IF_ID = add with rs = 5 (0x00A43020) -> one cycle of PCWrite = 0, IFIDWrite = 0, ctrl_zero = 1, then normal; stall_count = 1.
- rt rules: idex_rt = 4 with lw consumer rt = 4 (0x8C040000) -> no stall. With sw rt = 4 (0xAC040000) -> stall. With idex_rt = 0 and rs = 0 -> no stall.
- LOAD_BUBBLES = 3 with mem_stall pulsed for 1 cycle in the second bubble -> 4 cycles of IFIDWrite = 0, pipe_hold = 1 only in the frozen cycle, stall_count = 3.
- Branch abort: LOAD_BUBBLES = 3, branch_taken in the second bubble -> if_flush = ex_flush = 1 and PCWrite = 1 in that cycle; RUN the next cycle; stall_count = 1.
- Saturation: CNT_W = 4, 20 hazards -> stall_count stays at 15.
